// File: rtl/alarm_unit.sv
// Alarm unit: settable HH:MM alarm with arm toggle, ring timeout and snooze.
// Compares against an external time-of-day and drives a registered buzzer.
module alarm_unit #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       inc,
  input  logic       dec,
  input  logic       stop,
  input  logic       snooze,
  input  logic [4:0] hrs,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [4:0] alm_hr,
  output logic [5:0] alm_min,
  output logic       armed,
  output logic       ring,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET_HR  = 3'd1,
    S_SET_MIN = 3'd2,
    S_RING    = 3'd3,
    S_SNOOZE  = 3'd4
  } state_t;

  state_t     r_state, w_nxt;
  logic [4:0] r_alm_hr, w_alm_hr;
  logic [5:0] r_alm_min, w_alm_min;
  logic       r_armed, w_armed;
  logic       r_ring;
  logic [2:0] r_cnt, w_cnt;
  logic [7:0] r_rsec, w_rsec;
  logic [4:0] r_tgt_hr, w_tgt_hr;
  logic [5:0] r_tgt_min, w_tgt_min;
  logic       r_match_q;
  logic       r_smatch_q;
  logic [5:0] r_sec_q;

  logic       w_match, w_trig;
  logic       w_smatch, w_strig;
  logic       w_tick;
  logic       w_up, w_dn;
  logic [6:0] w_sum;
  logic       w_carry;
  logic [5:0] w_snz_min;
  logic [4:0] w_snz_hr;

  assign w_match  = r_armed && (hrs == r_alm_hr)
                    && (min == r_alm_min) && (sec == 6'd0);
  assign w_trig   = w_match && !r_match_q;
  assign w_smatch = (hrs == r_tgt_hr) && (min == r_tgt_min)
                    && (sec == 6'd0);
  assign w_strig  = w_smatch && !r_smatch_q;
  assign w_tick   = (sec != r_sec_q);
  assign w_up     = inc && !dec;
  assign w_dn     = dec && !inc;

  // Snooze target: press time plus SNOOZE_MIN, carrying into the hour.
  assign w_sum     = {1'b0, min} + 7'(SNOOZE_MIN);
  assign w_carry   = (w_sum >= 7'd60);
  assign w_snz_min = w_carry ? 6'(w_sum - 7'd60) : w_sum[5:0];
  assign w_snz_hr  = !w_carry ? hrs
                   : (hrs == 5'd23) ? 5'd0 : hrs + 5'd1;

  always_comb begin
    w_nxt     = r_state;
    w_alm_hr  = r_alm_hr;
    w_alm_min = r_alm_min;
    w_armed   = r_armed;
    w_cnt     = r_cnt;
    w_rsec    = r_rsec;
    w_tgt_hr  = r_tgt_hr;
    w_tgt_min = r_tgt_min;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_nxt  = S_RING;
          w_cnt  = 3'd0;
          w_rsec = 8'd0;
        end else if (mode) begin
          w_nxt = S_SET_HR;
        end else if (w_up || w_dn) begin
          w_armed = !r_armed;
        end
      end
      S_SET_HR: begin
        if (mode) begin
          w_nxt = S_SET_MIN;
        end else if (w_up) begin
          w_alm_hr = (r_alm_hr == 5'd23) ? 5'd0 : r_alm_hr + 5'd1;
        end else if (w_dn) begin
          w_alm_hr = (r_alm_hr == 5'd0) ? 5'd23 : r_alm_hr - 5'd1;
        end
      end
      S_SET_MIN: begin
        if (mode) begin
          w_nxt = S_IDLE;
        end else if (w_up) begin
          w_alm_min = (r_alm_min == 6'd59) ? 6'd0 : r_alm_min + 6'd1;
        end else if (w_dn) begin
          w_alm_min = (r_alm_min == 6'd0) ? 6'd59 : r_alm_min - 6'd1;
        end
      end
      S_RING: begin
        // An exhausted snooze behaves exactly like stop.
        if (stop || (snooze && (r_cnt >= 3'(MAX_SNOOZE)))) begin
          w_nxt = S_IDLE;
        end else if (snooze) begin
          w_nxt     = S_SNOOZE;
          w_cnt     = r_cnt + 3'd1;
          w_tgt_hr  = w_snz_hr;
          w_tgt_min = w_snz_min;
        end else if (w_tick) begin
          if (r_rsec == 8'(RING_SEC - 1)) begin
            w_nxt = S_IDLE;
          end else begin
            w_rsec = r_rsec + 8'd1;
          end
        end
      end
      S_SNOOZE: begin
        if (stop) begin
          w_nxt = S_IDLE;
        end else if (w_strig) begin
          w_nxt  = S_RING;
          w_rsec = 8'd0;
        end
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_alm_hr   <= 5'd0;
      r_alm_min  <= 6'd0;
      r_armed    <= 1'b0;
      r_ring     <= 1'b0;
      r_cnt      <= 3'd0;
      r_rsec     <= 8'd0;
      r_tgt_hr   <= 5'd0;
      r_tgt_min  <= 6'd0;
      r_match_q  <= 1'b1;
      r_smatch_q <= 1'b1;
      r_sec_q    <= 6'd0;
    end else begin
      r_state    <= w_nxt;
      r_alm_hr   <= w_alm_hr;
      r_alm_min  <= w_alm_min;
      r_armed    <= w_armed;
      r_ring     <= (w_nxt == S_RING);
      r_cnt      <= w_cnt;
      r_rsec     <= w_rsec;
      r_tgt_hr   <= w_tgt_hr;
      r_tgt_min  <= w_tgt_min;
      r_match_q  <= w_match;
      r_smatch_q <= w_smatch;
      r_sec_q    <= sec;
    end
  end

  assign alm_hr  = r_alm_hr;
  assign alm_min = r_alm_min;
  assign armed   = r_armed;
  assign ring    = r_ring;
  assign state   = r_state;

endmodule

// File: tb/tb_alarm_unit.sv
// Bench for alarm_unit: directed scenarios plus random pulses, all
// compared against a minutes-of-day reference model via a scoreboard.
module tb_alarm_unit;

  localparam int SNZ  = 5;
  localparam int RSEC = 3;
  localparam int MAXS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode = 0, inc = 0, dec = 0, stop = 0, snooze = 0;
  logic [4:0] hrs = 0;
  logic [5:0] min = 0, sec = 0;
  logic [4:0] alm_hr;
  logic [5:0] alm_min;
  logic       armed, ring;
  logic [2:0] state;

  alarm_unit #(
    .SNOOZE_MIN(SNZ),
    .RING_SEC(RSEC),
    .MAX_SNOOZE(MAXS)
  ) dut (
    .clk(clk), .rst(rst),
    .mode(mode), .inc(inc), .dec(dec),
    .stop(stop), .snooze(snooze),
    .hrs(hrs), .min(min), .sec(sec),
    .alm_hr(alm_hr), .alm_min(alm_min),
    .armed(armed), .ring(ring), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       rg;
    logic       ar;
    logic [4:0] ah;
    logic [5:0] am;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  // Reference model: alarm and snooze target kept as minutes of day.
  int m_state, m_alm, m_arm, m_cnt, m_rsec, m_tgt;
  int m_mq, m_smq, m_secq;

  task automatic model_reset();
    m_state = 0; m_alm = 0; m_arm = 0; m_cnt = 0;
    m_rsec = 0; m_tgt = 0; m_mq = 1; m_smq = 1; m_secq = 0;
  endtask

  task automatic model_step(input bit md, ic, dc, sp, sz,
                            input int h, m, s);
    int now;
    bit match, smatch, trig, strig, tick, up, dn;
    now    = h * 60 + m;
    match  = m_arm != 0 && now == m_alm && s == 0;
    smatch = now == m_tgt && s == 0;
    trig   = match && m_mq == 0;
    strig  = smatch && m_smq == 0;
    tick   = s != m_secq;
    up     = ic && !dc;
    dn     = dc && !ic;
    case (m_state)
      0: if (trig) begin
           m_state = 3; m_cnt = 0; m_rsec = 0;
         end else if (md) m_state = 1;
         else if (up || dn) m_arm = 1 - m_arm;
      1: if (md) m_state = 2;
         else if (up) m_alm = ((m_alm / 60 + 1) % 24) * 60 + m_alm % 60;
         else if (dn) m_alm = ((m_alm / 60 + 23) % 24) * 60 + m_alm % 60;
      2: if (md) m_state = 0;
         else if (up) m_alm = (m_alm / 60) * 60 + (m_alm % 60 + 1) % 60;
         else if (dn) m_alm = (m_alm / 60) * 60 + (m_alm % 60 + 59) % 60;
      3: if (sp || (sz && m_cnt >= MAXS)) m_state = 0;
         else if (sz) begin
           m_state = 4; m_cnt++; m_tgt = (now + SNZ) % 1440;
         end else if (tick) begin
           m_rsec++;
           if (m_rsec == RSEC) m_state = 0;
         end
      default: if (sp) m_state = 0;
         else if (strig) begin
           m_state = 3; m_rsec = 0;
         end
    endcase
    m_mq = match; m_smq = smatch; m_secq = s;
  endtask

  task automatic step(input bit md, ic, dc, sp, sz, input int h, m, s);
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    mode = md; inc = ic; dec = dc; stop = sp; snooze = sz;
    hrs = 5'(h); min = 6'(m); sec = 6'(s);
    model_step(md, ic, dc, sp, sz, h, m, s);
    e.st = 3'(m_state);
    e.rg = (m_state == 3);
    e.ar = m_arm[0];
    e.ah = 5'(m_alm / 60);
    e.am = 6'(m_alm % 60);
    q.push_back(e);
  endtask

  task automatic idle(input int n, input int h, m, s);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, h, m, s);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if ({state, ring, armed, alm_hr, alm_min} !==
          {e.st, e.rg, e.ar, e.ah, e.am}) begin
        n_err++;
        $display("FAIL sb t=%0t: got st=%0d rg=%0d ar=%0d %0d:%0d expected st=%0d rg=%0d ar=%0d %0d:%0d",
                 $time, state, ring, armed, alm_hr, alm_min,
                 e.st, e.rg, e.ar, e.ah, e.am);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    model_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_ring", int'(ring), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_hr", int'(alm_hr), 0);
    chk("rst_min", int'(alm_min), 0);
  endtask

  initial begin
    int ntrig;
    bit prev;
    model_reset();
    #12;
    do_reset();

    // Wrap boundaries while setting.
    step(1, 0, 0, 0, 0, 12, 0, 30);
    step(0, 0, 1, 0, 0, 12, 0, 30);
    settle();
    chk("wrap_hr_dec", int'(alm_hr), 23);
    step(1, 0, 0, 0, 0, 12, 0, 30);
    step(0, 0, 1, 0, 0, 12, 0, 30);
    step(0, 1, 0, 0, 0, 12, 0, 30);
    settle();
    chk("wrap_min_inc", int'(alm_min), 0);
    chk("wrap_no_carry", int'(alm_hr), 23);
    step(0, 1, 1, 0, 0, 12, 0, 30);
    step(1, 0, 0, 0, 0, 12, 0, 30);

    // Set alarm to 7:29 and arm.
    do_reset();
    step(1, 0, 0, 0, 0, 12, 0, 30);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 12, 0, 30);
    step(1, 0, 0, 0, 0, 12, 0, 30);
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 0, 12, 0, 30);
    step(0, 0, 1, 0, 0, 12, 0, 30);
    step(1, 0, 0, 0, 0, 12, 0, 30);
    step(0, 1, 0, 0, 0, 12, 0, 30);
    settle();
    chk("set_hr", int'(alm_hr), 7);
    chk("set_min", int'(alm_min), 29);
    chk("set_armed", int'(armed), 1);
    chk("set_state", int'(state), 0);

    // Trigger once, then hold sec=0.
    step(0, 0, 0, 0, 0, 7, 28, 59);
    settle();
    chk("pre_match_ring", int'(ring), 0);
    ntrig = 0;
    prev = ring;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 0, 0, 7, 29, 0);
      settle();
      if (ring && !prev) ntrig++;
      prev = ring;
    end
    chk("one_trigger", ntrig, 1);
    step(0, 0, 0, 1, 0, 7, 29, 0);
    idle(5, 7, 29, 0);
    settle();
    chk("no_retrigger", int'(ring), 0);

    // Move alarm to 23:58.
    step(1, 0, 0, 0, 0, 12, 0, 30);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 12, 0, 30);
    step(1, 0, 0, 0, 0, 12, 0, 30);
    for (int i = 0; i < 29; i++) step(0, 1, 0, 0, 0, 12, 0, 30);
    step(1, 0, 0, 0, 0, 12, 0, 30);

    // Snooze with midnight wrap, then exhaust snoozes.
    step(0, 0, 0, 0, 0, 23, 57, 59);
    step(0, 0, 0, 0, 0, 23, 58, 0);
    settle();
    chk("ring_2358", int'(ring), 1);
    step(0, 0, 0, 0, 1, 23, 58, 0);
    settle();
    chk("snz_state", int'(state), 4);
    chk("snz_ring", int'(ring), 0);
    step(0, 0, 0, 0, 0, 0, 2, 59);
    step(0, 0, 0, 0, 0, 0, 3, 0);
    settle();
    chk("snz_wrap_ring", int'(ring), 1);
    step(0, 0, 0, 0, 1, 0, 3, 0);
    step(0, 0, 0, 0, 0, 0, 7, 59);
    step(0, 0, 0, 0, 0, 0, 8, 0);
    step(0, 0, 0, 0, 1, 0, 8, 0);
    step(0, 0, 0, 0, 0, 0, 12, 59);
    step(0, 0, 0, 0, 0, 0, 13, 0);
    settle();
    chk("snz3_ring", int'(ring), 1);
    step(0, 0, 0, 0, 1, 0, 13, 0);
    settle();
    chk("snz4_state", int'(state), 0);

    // Ring timeout after RSEC ticks.
    step(0, 0, 0, 0, 0, 23, 57, 59);
    step(0, 0, 0, 0, 0, 23, 58, 0);
    step(0, 0, 0, 0, 0, 23, 58, 1);
    step(0, 0, 0, 0, 0, 23, 58, 2);
    settle();
    chk("to_still_ring", int'(state), 3);
    step(0, 0, 0, 0, 0, 23, 58, 3);
    settle();
    chk("to_state", int'(state), 0);
    chk("to_ring", int'(ring), 0);

    // Stop wins over snooze.
    step(0, 0, 0, 0, 0, 23, 57, 59);
    step(0, 0, 0, 0, 0, 23, 58, 0);
    step(0, 0, 0, 1, 1, 23, 58, 0);
    settle();
    chk("stop_snz", int'(state), 0);

    // Asynchronous reset mid-ring.
    step(0, 0, 0, 0, 0, 23, 57, 59);
    step(0, 0, 0, 0, 0, 23, 58, 0);
    settle();
    chk("pre_rst_ring", int'(ring), 1);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_ring", int'(ring), 0);
    chk("arst_armed", int'(armed), 0);
    chk("arst_hr", int'(alm_hr), 0);
    chk("arst_min", int'(alm_min), 0);

    // Random pulses around the alarm and snooze times.
    for (int i = 0; i < 600; i++) begin
      int h, m, s, t;
      bit md, ic, dc, sp, sz;
      md = ($urandom_range(0, 9) == 0);
      ic = ($urandom_range(0, 5) == 0);
      dc = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 19) == 0);
      sz = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: begin t = m_alm; s = 0; end
        1: begin t = (m_alm + 1439) % 1440; s = 59; end
        2: begin t = m_tgt; s = $urandom_range(0, 1); end
        default: begin t = $urandom_range(0, 1439); s = $urandom_range(0, 59); end
      endcase
      h = t / 60;
      m = t % 60;
      step(md, ic, dc, sp, sz, h, m, s);
    end
    settle();
    settle();
    chk("sb_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alarm_unit.md
ALARM_UNIT -- requirements
Module: alarm_unit

Interface
REQ-001 Parameter SNOOZE_MIN, default 5: minutes added per snooze (1..59).
REQ-002 Parameter RING_SEC, default 60: seconds of ringing before auto-stop (1..255).
REQ-003 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event (1..7).
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 mode  input  1  single-cycle pulse, advances setting state.
REQ-007 inc  input  1  single-cycle pulse, increment field / toggle arm.
REQ-008 dec  input  1  single-cycle pulse, decrement field / toggle arm.
REQ-009 stop  input  1  single-cycle pulse, silence alarm.
REQ-010 snooze  input  1  single-cycle pulse, defer alarm.
REQ-011 hrs  input  5  current time hours from clock block, 0..23.
REQ-012 min  input  6  current time minutes, 0..59.
REQ-013 sec  input  6  current time seconds, 0..59.
REQ-014 alm_hr  output  5  stored alarm hour.
REQ-015 alm_min  output  6  stored alarm minute.
REQ-016 armed  output  1  alarm enabled.
REQ-017 ring  output  1  buzzer drive, high only in RING.
REQ-018 state  output  3  FSM state code: IDLE=0, SET_HR=1, SET_MIN=2, RING=3, SNOOZE=4.

Function
REQ-019 FSM SHALL have states IDLE, SET_HR, SET_MIN, RING, SNOOZE; all transitions registered, effective one cycle after the causing pulse.
REQ-020 IDLE: mode -> SET_HR; inc or dec (not both) toggles armed; inc and dec same cycle -> no change.
REQ-021 SET_HR: inc/dec modify alm_hr mod 24 (23+1=0, 0-1=23); mode -> SET_MIN; inc and dec same cycle -> no change.
REQ-022 SET_MIN: inc/dec modify alm_min mod 60 (59+1=0, 0-1=59); mode -> IDLE; no carry into alm_hr.
REQ-023 Match SHALL be registered: match = armed && hrs==alm_hr && min==alm_min && sec==0; trigger = match && !match_q (rising edge only, one trigger per minute).
REQ-024 Trigger acts only in IDLE: IDLE -> RING, snooze count cleared to 0, ring-seconds counter cleared; trigger in SET_HR/SET_MIN SHALL be ignored (missed, not deferred).
REQ-025 Second tick = (sec != sec_q), sec_q a registered copy of sec; RING counts ticks; at RING_SEC ticks -> IDLE (auto-stop).
REQ-026 RING: stop -> IDLE; snooze with count < MAX_SNOOZE -> SNOOZE, count+1, target = (hrs:min at press) + SNOOZE_MIN with minute wrap 59->0 carrying hour, hour wrap 23->0.
REQ-027 RING: snooze with count == MAX_SNOOZE SHALL be treated as stop; stop and snooze same cycle -> stop wins; mode/inc/dec ignored.
REQ-028 SNOOZE: ring=0; rising edge of (hrs==tgt_hr && min==tgt_min && sec==0) -> RING with ring counter cleared, count retained; stop -> IDLE; mode/inc/dec/snooze ignored.
REQ-029 armed, alm_hr, alm_min SHALL be unchanged by RING/SNOOZE/auto-stop.
REQ-030 ring SHALL be a registered output equal to (state==RING), no combinational path from inputs.

Reset
REQ-031 rst=0 SHALL immediately force: state=IDLE, alm_hr=0, alm_min=0, armed=0, ring=0, snooze count=0, ring counter=0, target=0:00, match_q=1, sec_q=0 (match_q=1 suppresses a spurious trigger on the first cycle after release).
REQ-032 Reset asserted mid-RING or mid-SNOOZE SHALL drop ring within the same cycle (asynchronous) and discard the pending snooze.
REQ-033 After rst returns to 1, first state change occurs on the next rising clk edge.

Verification
REQ-034 Set: reset; mode, inc x7, mode, inc x30, dec x1, mode, inc -> alm_hr=7, alm_min=29, armed=1, state=0.
REQ-035 Wrap: in SET_HR dec from 0 -> 23; in SET_MIN inc from 59 -> 0, alm_hr unchanged.
REQ-036 Trigger: alarm 7:29 armed, drive time 7:28:59 -> 7:29:00 -> ring=1 one cycle after match; hold sec=0 for 100 cycles -> exactly one trigger.
REQ-037 Snooze: ringing at 23:58, pulse snooze -> state=4, ring=0; time 0:03:00 -> ring=1 (hour wrap); snooze x3 total then 4th snooze -> state=0.
REQ-038 Timeout: RING_SEC=3, ringing, advance sec 0->1->2->3 -> state=0, ring=0 after third tick; stop+snooze same cycle while ringing -> state=0.
REQ-039 Reset mid-ring: ring=1, rst=0 between clock edges -> ring=0 before next edge, armed=0, alm_hr=0, alm_min=0.
